// File: rtl/fade_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fade_pkg : colour type, keyframe table and state encoding for the fader     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package fade_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int NUM_KEYS = 6;

    // Entry 0 sits in the least significant slot.
    localparam rgb_t [NUM_KEYS-1:0] KEYS = {
        24'hff00ff,
        24'h0000ff,
        24'h00ffff,
        24'h00ff00,
        24'hffff00,
        24'hff0000
    };

    typedef enum logic [0:0] {
        FADE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [2:0] next_key(input logic [2:0] k);
        return (k == 3'(NUM_KEYS - 1)) ? 3'd0 : k + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fade_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fade_sequencer_if : control inputs and pwm duty outputs of the sequencer    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fade_sequencer_if;
    logic       en;
    logic       period_end;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       upd;

    modport master (
        output en,
        output period_end,
        input  red,
        input  green,
        input  blue,
        input  upd
    );

    modport slave (
        input  en,
        input  period_end,
        output red,
        output green,
        output blue,
        output upd
    );
endinterface
`default_nettype wire

// File: rtl/fade_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fade_channel : 8-bit register stepping by one toward a target per step     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fade_channel (
    input  logic       clk,
    input  logic       r_n,
    input  logic       step,
    input  logic [7:0] target,
    output logic [7:0] value,
    output logic       at_target
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (step && (value_q != target)) begin
            value_d = (value_q < target) ? value_q + 8'd1 : value_q - 8'd1;
        end
    end

    // Reflects the value after this cycle's update, so the sequencer can
    // leave FADE on the very tick the last channel lands.
    assign at_target = (value_d == target);
    assign value     = value_q;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            value_q <= 8'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fade_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fade_sequencer : steps an RGB colour through six keyframes for pwm drivers |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fade_sequencer
    import fade_pkg::*;
#(
    parameter int STEP_DIV   = 65536,
    parameter int HOLD_STEPS = 64
) (
    input  logic             clk,
    input  logic             r_n,
    fade_sequencer_if.slave  bus
);

    localparam int               DIV_W     = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_STEPS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       hold_q, hold_d;
    logic [2:0]       key_q, key_d;
    state_t           state_q, state_d;
    logic [7:0]       red_q, red_d;
    logic [7:0]       green_q, green_d;
    logic [7:0]       blue_q, blue_d;
    logic             upd_q, upd_d;

    logic             tick;
    logic             step;
    rgb_t             target;
    rgb_t             work;
    logic [2:0]       at_tgt;

    assign tick   = bus.en && (div_q == DIV_LAST);
    assign step   = tick && (state_q == FADE);
    assign target = KEYS[key_q];

    fade_channel u_ch_r (
        .clk       (clk),
        .r_n       (r_n),
        .step      (step),
        .target    (target.r),
        .value     (work.r),
        .at_target (at_tgt[2])
    );

    fade_channel u_ch_g (
        .clk       (clk),
        .r_n       (r_n),
        .step      (step),
        .target    (target.g),
        .value     (work.g),
        .at_target (at_tgt[1])
    );

    fade_channel u_ch_b (
        .clk       (clk),
        .r_n       (r_n),
        .step      (step),
        .target    (target.b),
        .value     (work.b),
        .at_target (at_tgt[0])
    );

    always_comb begin
        div_d   = div_q;
        hold_d  = hold_q;
        key_d   = key_q;
        state_d = state_q;

        if (bus.en) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        if (tick) begin
            case (state_q)
                FADE: begin
                    if (&at_tgt) begin
                        state_d = HOLD;
                        hold_d  = 8'd0;
                    end
                end
                HOLD: begin
                    hold_d = hold_q + 8'd1;
                    if (hold_q == HOLD_LAST) begin
                        key_d   = next_key(key_q);
                        state_d = FADE;
                    end
                end
                default: state_d = FADE;
            endcase
        end
    end

    // Outputs sample the working colour before any step taken this cycle.
    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        upd_d   = 1'b0;
        if (bus.period_end) begin
            red_d   = work.r;
            green_d = work.g;
            blue_d  = work.b;
            upd_d   = (work != {red_q, green_q, blue_q});
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            div_q   <= '0;
            hold_q  <= 8'd0;
            key_q   <= 3'd0;
            state_q <= FADE;
            red_q   <= 8'd0;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
            upd_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            state_q <= state_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.red   = red_q;
    assign bus.green = green_q;
    assign bus.blue  = blue_q;
    assign bus.upd   = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_fade_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fade_sequencer : directed checks of the fader with STEP_DIV=4, HOLD=2    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fade_sequencer;

    logic clk = 1'b0;
    logic r_n;
    int   errors = 0;
    int   checks = 0;
    logic seen_upd;
    logic seen_chg;

    always #5 clk = ~clk;

    fade_sequencer_if bus_if ();

    fade_sequencer #(
        .STEP_DIV   (4),
        .HOLD_STEPS (2)
    ) dut (
        .clk (clk),
        .r_n (r_n),
        .bus (bus_if)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input logic [23:0] exp);
        chk({tag, ".red"},   bus_if.red,   exp[23:16]);
        chk({tag, ".green"}, bus_if.green, exp[15:8]);
        chk({tag, ".blue"},  bus_if.blue,  exp[7:0]);
    endtask

    // Advance n rising edges, then sit on the following falling edge.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        r_n               = 1'b0;
        bus_if.en         = 1'b0;
        bus_if.period_end = 1'b0;
        #2;
        chk_rgb("reset", 24'h000000);
        chk("reset.upd", {7'd0, bus_if.upd}, 8'd0);

        @(negedge clk);
        r_n               = 1'b1;
        bus_if.en         = 1'b1;
        bus_if.period_end = 1'b1;

        // Tick k lands on edge 4k; outputs show it one edge later.
        adv(4);
        chk("first_tick_prestep.red", bus_if.red, 8'h00);
        adv(1);
        chk("first_step.red", bus_if.red, 8'h01);
        chk("first_step.upd", {7'd0, bus_if.upd}, 8'd1);
        adv(1);
        chk("no_change.red", bus_if.red, 8'h01);
        chk("no_change.upd", {7'd0, bus_if.upd}, 8'd0);
        adv(1014);
        chk_rgb("edge1020", 24'hfe0000);
        adv(1);
        chk("red_full.red", bus_if.red, 8'hff);
        chk("red_full.upd", {7'd0, bus_if.upd}, 8'd1);
        adv(11);
        chk_rgb("hold_key0", 24'hff0000);
        adv(1);
        chk_rgb("green_start", 24'hff0100);
        chk("green_start.upd", {7'd0, bus_if.upd}, 8'd1);
        adv(1016);
        chk_rgb("key1_reached", 24'hffff00);

        // Starve the output path while red fades down toward key 2.
        bus_if.period_end = 1'b0;
        seen_upd = 1'b0;
        seen_chg = 1'b0;
        for (int i = 0; i < 200; i++) begin
            adv(1);
            if (bus_if.upd !== 1'b0) seen_upd = 1'b1;
            if ({bus_if.red, bus_if.green, bus_if.blue} !== 24'hffff00) seen_chg = 1'b1;
        end
        chk("pe_low.upd_seen", {7'd0, seen_upd}, 8'd0);
        chk("pe_low.out_changed", {7'd0, seen_chg}, 8'd0);
        bus_if.period_end = 1'b1;
        adv(1);
        chk_rgb("pe_pulse", 24'hcfff00);
        chk("pe_pulse.upd", {7'd0, bus_if.upd}, 8'd1);
        bus_if.period_end = 1'b0;
        adv(1);
        chk("pe_after.red", bus_if.red, 8'hcf);
        chk("pe_after.upd", {7'd0, bus_if.upd}, 8'd0);
        bus_if.period_end = 1'b1;
        adv(3);
        chk("pre_freeze.red", bus_if.red, 8'hce);

        // Freeze with the divider at 2.
        bus_if.en = 1'b0;
        seen_upd = 1'b0;
        seen_chg = 1'b0;
        for (int i = 0; i < 100; i++) begin
            adv(1);
            if (bus_if.upd !== 1'b0) seen_upd = 1'b1;
            if ({bus_if.red, bus_if.green, bus_if.blue} !== 24'hceff00) seen_chg = 1'b1;
        end
        chk("freeze.upd_seen", {7'd0, seen_upd}, 8'd0);
        chk("freeze.out_changed", {7'd0, seen_chg}, 8'd0);
        bus_if.en = 1'b1;
        adv(2);
        chk("resume_prestep.red", bus_if.red, 8'hce);
        adv(1);
        chk("resume_step.red", bus_if.red, 8'hcd);
        chk("resume_step.upd", {7'd0, bus_if.upd}, 8'd1);

        adv(1848);
        chk_rgb("key3_reached", 24'h00ffff);
        adv(2056);
        chk_rgb("key5_reached", 24'hff00ff);
        adv(11);
        chk_rgb("key5_hold_end", 24'hff00ff);
        adv(1);
        chk_rgb("wrap_first_step", 24'hff00fe);
        adv(1015);
        chk_rgb("wrap_near_end", 24'hff0001);
        adv(1);
        chk_rgb("wrap_key0", 24'hff0000);
        chk("wrap_key0.upd", {7'd0, bus_if.upd}, 8'd1);

        // Asynchronous reset between edges in the middle of a fade.
        adv(111);
        #2;
        r_n = 1'b0;
        #1;
        chk_rgb("async_reset", 24'h000000);
        chk("async_reset.upd", {7'd0, bus_if.upd}, 8'd0);
        @(negedge clk);
        r_n = 1'b1;
        adv(4);
        chk_rgb("restart_prestep", 24'h000000);
        adv(1);
        chk_rgb("restart_step", 24'h010000);
        chk("restart_step.upd", {7'd0, bus_if.upd}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
